// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART receive path
package uart_pkg;

  localparam int OVERSAMPLE = 8;
  localparam int TIMER_W    = 19;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic logic [TIMER_W-1:0] bit_period(input logic [15:0] prescale);
    logic [TIMER_W-1:0] p;
    p = (prescale == 16'd0) ? TIMER_W'(1) : TIMER_W'(prescale);
    return p * TIMER_W'(OVERSAMPLE);
  endfunction

  // The reserved encoding behaves exactly like "no parity".
  function automatic parity_mode_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return PAR_ODD;
      2'd2:    return PAR_EVEN;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO with occupancy output
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == (AW+1)'(DEPTH));

  // A write into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - parametrised UART receiver with parity, stop-bit checks and output FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   prescale,
  input  logic [1:0]                    parity_mode,
  input  logic                          rxd,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          rx_busy,
  output logic                          rx_overrun_error,
  output logic                          rx_frame_error,
  output logic                          rx_parity_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic [1:0]            rxd_sync;
  logic                  rxd_s;
  logic                  rxd_q;
  rx_state_t             state;
  logic [TIMER_W-1:0]    timer;
  logic [TIMER_W-1:0]    period;
  logic [TIMER_W-1:0]    t_now;
  parity_mode_t          par;
  logic [DATA_WIDTH-1:0] shreg;
  logic [3:0]            bit_cnt;
  logic                  perr;
  logic                  expire;
  logic                  start_edge;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_sync <= 2'b11;
      rxd_q    <= 1'b1;
    end else begin
      rxd_sync <= {rxd_sync[0], rxd};
      rxd_q    <= rxd_sync[1];
    end
  end

  assign rxd_s      = rxd_sync[1];
  assign start_edge = rxd_q & ~rxd_s;
  assign expire     = (timer == '0);
  assign t_now      = bit_period(prescale);
  assign pop        = m_axis_tvalid & m_axis_tready;
  assign push       = (state == STOP) && expire && rxd_s && (bit_cnt == 4'(STOP_BITS-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      timer            <= '0;
      period           <= '0;
      par              <= PAR_NONE;
      shreg            <= '0;
      bit_cnt          <= '0;
      perr             <= 1'b0;
      rx_busy          <= 1'b0;
      rx_frame_error   <= 1'b0;
      rx_parity_error  <= 1'b0;
      rx_overrun_error <= 1'b0;
    end else begin
      rx_frame_error   <= 1'b0;
      rx_parity_error  <= 1'b0;
      rx_overrun_error <= push & fifo_full & ~pop;
      // Reload with period-1 so consecutive samples land exactly one bit period apart.
      if (state != IDLE && state != BREAK)
        timer <= expire ? period - TIMER_W'(1) : timer - TIMER_W'(1);
      case (state)
        IDLE: begin
          if (start_edge) begin
            state   <= START;
            rx_busy <= 1'b1;
            period  <= t_now;
            timer   <= t_now >> 1;
            par     <= decode_parity(parity_mode);
            perr    <= 1'b0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (expire) begin
            if (rxd_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (expire) begin
            shreg <= {rxd_s, shreg[DATA_WIDTH-1:1]};
            if (bit_cnt == 4'(DATA_WIDTH-1)) begin
              bit_cnt <= '0;
              state   <= (par == PAR_NONE) ? STOP : PARITY;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PARITY: begin
          if (expire) begin
            perr  <= (par == PAR_ODD) ? ~(^{shreg, rxd_s}) : (^{shreg, rxd_s});
            state <= STOP;
          end
        end
        STOP: begin
          if (expire) begin
            if (!rxd_s) begin
              rx_frame_error <= 1'b1;
              bit_cnt        <= '0;
              state          <= BREAK;
            end else if (bit_cnt == 4'(STOP_BITS-1)) begin
              rx_parity_error <= perr;
              bit_cnt         <= '0;
              rx_busy         <= 1'b0;
              state           <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        BREAK: begin
          if (rxd_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({perr, shreg}),
    .rd_en   (m_axis_tready),
    .rd_data (fifo_out),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_out[DATA_WIDTH-1:0];
  assign m_axis_tuser  = fifo_out[DATA_WIDTH];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo against a frame-level reference model
module tb_uart_rx_fifo;

  typedef struct {
    int data;
    int user;
    int lo;
    int hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] ps0 = 16'd1;
  logic [1:0]  pm0 = 2'd0;
  logic        rxd0 = 1'b1;
  logic        tready0 = 1'b1;
  logic [7:0]  tdata0;
  logic        tuser0, tvalid0, busy0, ovr0, ferr0, perr0;
  logic [4:0]  lvl0;

  logic [15:0] ps1 = 16'd1;
  logic [1:0]  pm1 = 2'd0;
  logic        rxd1 = 1'b1;
  logic        tready1 = 1'b0;
  logic [8:0]  tdata1;
  logic        tuser1, tvalid1, busy1, ovr1, ferr1, perr1;
  logic [2:0]  lvl1;

  uart_rx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .prescale(ps0), .parity_mode(pm0), .rxd(rxd0),
    .m_axis_tdata(tdata0), .m_axis_tuser(tuser0), .m_axis_tvalid(tvalid0),
    .m_axis_tready(tready0), .rx_busy(busy0), .rx_overrun_error(ovr0),
    .rx_frame_error(ferr0), .rx_parity_error(perr0), .fifo_level(lvl0)
  );

  uart_rx_fifo #(.DATA_WIDTH(9), .FIFO_DEPTH(4), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .prescale(ps1), .parity_mode(pm1), .rxd(rxd1),
    .m_axis_tdata(tdata1), .m_axis_tuser(tuser1), .m_axis_tvalid(tvalid1),
    .m_axis_tready(tready1), .rx_busy(busy1), .rx_overrun_error(ovr1),
    .rx_frame_error(ferr1), .rx_parity_error(perr1), .fifo_level(lvl1)
  );

  exp_t       q0[$];
  exp_t       q1[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cnt[2][3];
  int         expc[2][3];
  logic [2:0] prev_p[2];
  string      pn[3] = '{"parity", "frame", "overrun"};

  function automatic void chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endfunction

  // Parity bit that makes the frame correct for the given mode.
  function automatic int good_par(input int data, input int mode);
    int pc;
    pc = $countones(data);
    return (mode == 1) ? ((pc % 2 == 0) ? 1 : 0) : (pc % 2);
  endfunction

  function automatic void take_word(input int d, input int data, input int user);
    exp_t  e;
    string tag;
    tag = d ? "dut1" : "dut0";
    if ((d ? q1.size() : q0.size()) == 0) begin
      chk({tag, " unexpected word"}, data, -1);
      return;
    end
    if (d) e = q1.pop_front();
    else   e = q0.pop_front();
    chk({tag, " tdata"}, data, e.data);
    chk({tag, " tuser"}, user, e.user);
    if (e.hi != 0) chk_rng({tag, " tvalid latency"}, cyc, e.lo, e.hi);
  endfunction

  function automatic void take_pulses(input int d, input logic [2:0] cur);
    for (int k = 0; k < 3; k++) begin
      if (cur[k]) begin
        cnt[d][k]++;
        chk($sformatf("dut%0d %s pulse width", d, pn[k]), prev_p[d][k], 0);
      end
    end
    prev_p[d] = cur;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tvalid0 && tready0) take_word(0, tdata0, tuser0);
        if (tvalid1 && tready1) take_word(1, tdata1, tuser1);
        take_pulses(0, {ovr0, ferr0, perr0});
        take_pulses(1, {ovr1, ferr1, perr1});
      end
    end
  endtask

  task automatic chk_counts(input int d);
    for (int k = 0; k < 3; k++)
      chk($sformatf("dut%0d %s pulse count", d, pn[k]), cnt[d][k], expc[d][k]);
  endtask

  task automatic wait_drain(input int d, input int budget);
    int left;
    left = budget;
    while (left > 0 && ((d ? q1.size() : q0.size()) != 0 || (d ? tvalid1 : tvalid0))) begin
      @(posedge clk); #1;
      left--;
    end
    chk($sformatf("dut%0d words outstanding after drain", d), d ? q1.size() : q0.size(), 0);
  endtask

  task automatic chk_reset0();
    chk("rst tvalid0", tvalid0, 0);
    chk("rst tdata0", tdata0, 0);
    chk("rst tuser0", tuser0, 0);
    chk("rst level0", lvl0, 0);
    chk("rst busy0", busy0, 0);
    chk("rst pulses0", {ovr0, ferr0, perr0}, 0);
  endtask

  // Builds the serial frame, predicts the delivered word, then bit-bangs the pin.
  task automatic send_frame(input int d, input int data, input int par_bit,
                            input bit stop_ok, input bit scramble, input bit chk_time);
    int   t, dw, mode, n;
    int   bits[$];
    exp_t e;
    dw   = d ? 9 : 8;
    t    = (d ? ((ps1 == 0) ? 1 : int'(ps1)) : ((ps0 == 0) ? 1 : int'(ps0))) * 8;
    mode = d ? int'(pm1) : int'(pm0);
    bits.push_back(0);
    for (int i = 0; i < dw; i++) bits.push_back((data >> i) & 1);
    if (par_bit >= 0) bits.push_back(par_bit);
    bits.push_back(stop_ok ? 1 : 0);
    if (d == 1) bits.push_back(1);
    n = bits.size() - 1;
    @(posedge clk); #1;
    if (stop_ok) begin
      e.data = data;
      e.user = (par_bit >= 0 && (mode == 1 || mode == 2) && par_bit != good_par(data, mode)) ? 1 : 0;
      e.lo   = cyc + t / 2 + n * t;
      e.hi   = chk_time ? e.lo + 6 : 0;
      if (e.user != 0) expc[d][0]++;
      if ((d ? q1.size() : q0.size()) < (d ? 4 : 16)) begin
        if (d) q1.push_back(e);
        else   q0.push_back(e);
      end else begin
        expc[d][2]++;
      end
    end else begin
      expc[d][1]++;
    end
    foreach (bits[i]) begin
      if (d) rxd1 = 1'(bits[i]);
      else   rxd0 = 1'(bits[i]);
      if (i == 1 && scramble) begin
        if (d) begin ps1 = 16'($urandom_range(0, 7)); pm1 = 2'($urandom_range(0, 3)); end
        else   begin ps0 = 16'($urandom_range(0, 7)); pm0 = 2'($urandom_range(0, 3)); end
      end
      repeat (t) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1, "watchdog");
  end

  initial begin
    string msg;
    bit    busy_ok, lvl_ok, saw_busy, done;
    int    d, p, g;

    prev_p[0] = '0;
    prev_p[1] = '0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 3; k++) begin
        cnt[i][k]  = 0;
        expc[i][k] = 0;
      end
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_reset0();
    chk("rst tvalid1", tvalid1, 0);
    chk("rst level1", lvl1, 0);
    chk("rst busy1", busy1, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Plain 8N1 text with random inter-frame gaps.
    msg = "hello world";
    for (int i = 0; i < msg.len(); i++) begin
      send_frame(0, int'(msg[i]), -1, 1, 0, 1);
      repeat ($urandom_range(0, 49)) @(posedge clk);
    end
    wait_drain(0, 400);
    chk_counts(0);

    // Even parity: one correct frame, one with a wrong parity bit.
    pm0 = 2'd2;
    send_frame(0, 'h68, 1, 1, 0, 1);
    send_frame(0, 'h65, 1, 1, 0, 1);
    wait_drain(0, 400);
    chk_counts(0);

    // Frame error followed by a held break.
    pm0 = 2'd0;
    send_frame(0, 'h41, -1, 0, 0, 0);
    busy_ok = 1'b1;
    lvl_ok  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      busy_ok &= busy0;
      lvl_ok  &= (lvl0 == 0);
    end
    chk("busy held during break", busy_ok, 1);
    chk("level empty during break", lvl_ok, 1);
    rxd0 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("busy after break", busy0, 0);
    chk("level after break", lvl0, 0);
    send_frame(0, 'h42, -1, 1, 0, 1);
    wait_drain(0, 400);
    chk_counts(0);

    // Short glitch must be rejected as a false start.
    saw_busy = 1'b0;
    @(posedge clk); #1;
    rxd0 = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (i == 2) rxd0 = 1'b1;
      saw_busy |= busy0;
    end
    chk("glitch raised busy", saw_busy, 1);
    chk("glitch busy cleared", busy0, 0);
    chk("glitch level", lvl0, 0);
    chk_counts(0);

    // Randomised frames with mid-frame configuration changes and a jittery sink.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          ps0 = 16'($urandom_range(0, 3));
          pm0 = 2'($urandom_range(0, 3));
          d   = $urandom_range(0, 255);
          if (pm0 == 2'd1 || pm0 == 2'd2)
            p = good_par(d, int'(pm0)) ^ (($urandom_range(0, 3) == 0) ? 1 : 0);
          else
            p = -1;
          send_frame(0, d, p, 1, 1, 0);
          g = $urandom_range(0, 20);
          repeat (g) @(posedge clk);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          tready0 = 1'($urandom_range(0, 1));
        end
      end
    join
    tready0 = 1'b1;
    wait_drain(0, 400);
    chk_counts(0);

    // Small FIFO overflow on the 9-bit, two-stop-bit instance.
    ps1 = 16'd1;
    pm1 = 2'd0;
    tready1 = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(1, i, -1, 1, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("dut1 level when full", lvl1, 4);
    chk("dut1 tvalid when full", tvalid1, 1);
    chk_counts(1);
    tready1 = 1'b1;
    wait_drain(1, 100);
    chk("dut1 level drained", lvl1, 0);
    chk("dut1 tvalid drained", tvalid1, 0);

    // Odd parity on 9-bit words, one good and one corrupted.
    pm1 = 2'd1;
    ps1 = 16'd2;
    send_frame(1, 'h1A5, good_par('h1A5, 1), 1, 0, 0);
    send_frame(1, 'h0F3, 1 - good_par('h0F3, 1), 1, 0, 0);
    wait_drain(1, 400);
    chk_counts(1);

    // Reset in the middle of data bit 3 with two words buffered.
    ps0 = 16'd1;
    pm0 = 2'd0;
    tready0 = 1'b0;
    send_frame(0, 'h11, -1, 1, 0, 0);
    send_frame(0, 'h22, -1, 1, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("level before reset", lvl0, 2);
    d = 'h5A;
    rxd0 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rxd0 = 1'((d >> i) & 1);
      repeat (8) @(posedge clk);
      #1;
    end
    rxd0 = 1'((d >> 3) & 1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    q0.delete();
    #1;
    chk_reset0();
    rxd0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("level after reset", lvl0, 0);
    tready0 = 1'b1;
    send_frame(0, 'h5A, -1, 1, 0, 1);
    wait_drain(0, 400);
    chk_counts(0);
    chk_counts(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
